// File: rtl/quad_enc_pkg.sv
// Shared constants and helpers for the quadrature encoder front end.
package quad_enc_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_INC  = 2'd1,
    MV_DEC  = 2'd2,
    MV_ERR  = 2'd3
  } move_t;

  // Next {A,B} state when turning clockwise (A leads B).
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      ST_10:   n = ST_11;
      ST_11:   n = ST_01;
      ST_01:   n = ST_00;
      default: n = ST_10;
    endcase
    return n;
  endfunction

  // Classify the transition from prev to cur: no move, CW, CCW or both bits flipped.
  function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
    move_t m;
    if (cur == prev)               m = MV_NONE;
    else if (cur == cw_next(prev)) m = MV_INC;
    else if (prev == cw_next(cur)) m = MV_DEC;
    else                           m = MV_ERR;
    return m;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised input after it has differed for FILT_LEN cycles.
module enc_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the raw pin, then count consecutive mismatch cycles before accepting a change.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_enc_decoder.sv
// x4 quadrature decoder: filtered A/B/Z in, wrapping position, direction,
// step/index pulses and a sticky illegal-transition flag out.
module quad_enc_decoder
  import quad_enc_pkg::*;
#(
  parameter int CPR       = 14400,
  parameter int POS_W     = 16,
  parameter int FILT_LEN  = 3,
  parameter bit INDEX_RST = 1'b1
) (
  input  logic             I_CLK_100MHZ,
  input  logic             I_RST_N,
  input  logic             I_ENC_A,
  input  logic             I_ENC_B,
  input  logic             I_ENC_Z,
  input  logic             I_CLR,
  output logic [POS_W-1:0] O_POS,
  output logic             O_DIR,
  output logic             O_STEP,
  output logic             O_INDEX,
  output logic             O_ERR
);

  // HOLD lasts until the filters have settled on the resting state and the
  // previous-state register has captured that settled value once more.
  localparam int HOLD_W = $clog2(FILT_LEN + 3);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FILT_LEN + 2);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(CPR - 1);

  logic [2:0]       w_raw;
  logic [2:0]       w_filt;
  logic             w_a_f;
  logic             w_b_f;
  logic             w_z_f;
  logic [1:0]       w_state;
  move_t            w_move;
  logic             w_z_rise;
  logic [POS_W-1:0] w_pos_inc;
  logic [POS_W-1:0] w_pos_dec;

  fsm_t             r_fsm;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]       r_prev_state;
  logic             r_z_prev;
  logic [POS_W-1:0] r_pos;
  logic             r_dir;
  logic             r_step;
  logic             r_index;
  logic             r_err;

  assign w_raw = {I_ENC_Z, I_ENC_B, I_ENC_A};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      enc_input_filter #(
        .FILT_LEN(FILT_LEN)
      ) u_filt (
        .i_clk  (I_CLK_100MHZ),
        .i_rst_n(I_RST_N),
        .i_raw  (w_raw[gi]),
        .o_filt (w_filt[gi])
      );
    end
  endgenerate

  assign w_a_f     = w_filt[0];
  assign w_b_f     = w_filt[1];
  assign w_z_f     = w_filt[2];
  assign w_state   = {w_a_f, w_b_f};
  assign w_move    = classify(r_prev_state, w_state);
  assign w_z_rise  = w_z_f & ~r_z_prev;
  assign w_pos_inc = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
  assign w_pos_dec = (r_pos == '0) ? POS_MAX : r_pos - 1'b1;

  // Decoder FSM with registered outputs; priority on position is clear > index reload > step.
  always_ff @(posedge I_CLK_100MHZ) begin
    if (!I_RST_N) begin
      r_fsm        <= HOLD;
      r_hold_cnt   <= '0;
      r_prev_state <= ST_00;
      r_z_prev     <= 1'b0;
      r_pos        <= '0;
      r_dir        <= DIR_CCW;
      r_step       <= 1'b0;
      r_index      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_prev_state <= w_state;
      r_z_prev     <= w_z_f;
      r_step       <= 1'b0;
      r_index      <= 1'b0;
      case (r_fsm)
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) r_fsm <= RUN;
          else                         r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        RUN: begin
          case (w_move)
            MV_INC: begin
              r_pos  <= w_pos_inc;
              r_dir  <= DIR_CW;
              r_step <= 1'b1;
            end
            MV_DEC: begin
              r_pos  <= w_pos_dec;
              r_dir  <= DIR_CCW;
              r_step <= 1'b1;
            end
            MV_ERR:  r_err <= 1'b1;
            default: ;
          endcase
          if (w_z_rise) begin
            r_index <= 1'b1;
            if (INDEX_RST) r_pos <= '0;
          end
        end
        default: r_fsm <= HOLD;
      endcase
      if (I_CLR) begin
        r_pos <= '0;
        r_err <= 1'b0;
      end
    end
  end

  assign O_POS   = r_pos;
  assign O_DIR   = r_dir;
  assign O_STEP  = r_step;
  assign O_INDEX = r_index;
  assign O_ERR   = r_err;

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Directed bench for quad_enc_decoder: a vector table for stepping/wrap/clear/error
// plus hand-written sequences for latency, glitch, index and reset corner cases.
module tb_quad_enc_decoder;

  localparam int CPR      = 14400;
  localparam int POS_W    = 16;
  localparam int FILT_LEN = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enc_a, enc_b, enc_z, clr;
  logic [POS_W-1:0] pos;
  logic             dir, step, index, err;

  int n_cmp  = 0;
  int n_fail = 0;
  int step_cnt = 0;
  int idx_cnt  = 0;
  int both_cnt = 0;
  int cyc      = 0;

  typedef struct {
    logic a;
    logic b;
    logic clr;
    int   pos;
    logic dir;
    logic err;
    int   steps;
  } vec_t;

  vec_t vecs[19];

  quad_enc_decoder #(
    .CPR(CPR), .POS_W(POS_W), .FILT_LEN(FILT_LEN), .INDEX_RST(1'b1)
  ) dut (
    .I_CLK_100MHZ(clk),
    .I_RST_N     (rst_n),
    .I_ENC_A     (enc_a),
    .I_ENC_B     (enc_b),
    .I_ENC_Z     (enc_z),
    .I_CLR       (clr),
    .O_POS       (pos),
    .O_DIR       (dir),
    .O_STEP      (step),
    .O_INDEX     (index),
    .O_ERR       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step) step_cnt++;
    if (index) idx_cnt++;
    if (step && index) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic b, input logic c,
                              input int p, input logic d, input logic e, input int s);
    vec_t v;
    v.a = a; v.b = b; v.clr = c; v.pos = p; v.dir = d; v.err = e; v.steps = s;
    return v;
  endfunction

  logic [1:0] cw_seq [4];

  initial begin
    int s0, i0, b0, t0, lat;
    bit found;

    cw_seq[0] = 2'b10; cw_seq[1] = 2'b11; cw_seq[2] = 2'b01; cw_seq[3] = 2'b00;

    //                a     b     clr   pos    dir   err   steps
    vecs[0]  = mk(1'b0, 1'b0, 1'b1, 0,     1'b1, 1'b0, 0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 14399, 1'b0, 1'b0, 1);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1,     1'b1, 1'b0, 1);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 2,     1'b1, 1'b0, 1);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 3,     1'b1, 1'b0, 1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 4,     1'b1, 1'b0, 1);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 4,     1'b1, 1'b1, 0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 0,     1'b1, 1'b0, 0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1,     1'b1, 1'b0, 1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 2,     1'b1, 1'b0, 1);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1,     1'b0, 1'b0, 1);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 0,     1'b0, 1'b0, 1);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 14399, 1'b0, 1'b0, 1);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 14398, 1'b0, 1'b0, 1);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 14399, 1'b1, 1'b0, 1);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 0,     1'b1, 1'b0, 1);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 1,     1'b1, 1'b0, 1);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 2,     1'b1, 1'b0, 1);

    // Reset state
    rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0; clr = 1'b0;
    tick(3);
    chk("rst_pos", int'(pos), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_index", int'(index), 0);
    chk("rst_err", int'(err), 0);
    $display("reset: pos=%0d dir=%b step=%b index=%b err=%b", pos, dir, step, index, err);
    rst_n = 1'b1;
    tick(20);

    // 8 CW steps at 4 cycles/state; the first also measures input-to-output latency
    s0 = step_cnt;
    enc_a = 1'b1; enc_b = 1'b0;
    t0 = cyc;
    found = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (step) begin
        found = 1'b1;
        lat = cyc - t0;
      end
    end
    chk("step_latency", lat, FILT_LEN + 3);
    tick(4);
    for (int i = 1; i < 8; i++) begin
      {enc_a, enc_b} = cw_seq[i % 4];
      tick(4);
    end
    tick(6);
    chk("cw8_pos", int'(pos), 8);
    chk("cw8_dir", int'(dir), 1);
    chk("cw8_steps", step_cnt - s0, 8);
    chk("cw8_err", int'(err), 0);
    $display("cw8: pos=%0d dir=%b steps=%0d err=%b", pos, dir, step_cnt - s0, err);

    // Table-driven vectors
    for (int v = 0; v < 19; v++) begin
      s0 = step_cnt;
      enc_a = vecs[v].a; enc_b = vecs[v].b; clr = vecs[v].clr;
      tick(1);
      clr = 1'b0;
      tick(9);
      chk($sformatf("vec%0d_pos", v), int'(pos), vecs[v].pos);
      chk($sformatf("vec%0d_dir", v), int'(dir), int'(vecs[v].dir));
      chk($sformatf("vec%0d_err", v), int'(err), int'(vecs[v].err));
      chk($sformatf("vec%0d_steps", v), step_cnt - s0, vecs[v].steps);
      $display("vec %0d: ab=%b%b clr=%b pos=%0d dir=%b err=%b steps=%0d",
               v, vecs[v].a, vecs[v].b, vecs[v].clr, pos, dir, err, step_cnt - s0);
    end

    // 2-cycle glitch on A at state 00 must be rejected
    s0 = step_cnt;
    enc_a = 1'b1;
    tick(2);
    enc_a = 1'b0;
    tick(10);
    chk("glitch_pos", int'(pos), 2);
    chk("glitch_dir", int'(dir), 1);
    chk("glitch_steps", step_cnt - s0, 0);
    $display("glitch: pos=%0d dir=%b steps=%0d", pos, dir, step_cnt - s0);

    // Advance 35 CW steps to position 37 (ends at state 01)
    for (int i = 0; i < 35; i++) begin
      {enc_a, enc_b} = cw_seq[i % 4];
      tick(5);
    end
    tick(8);
    chk("pos37", int'(pos), 37);
    $display("advance: pos=%0d", pos);

    // Index pulse reloads position
    i0 = idx_cnt;
    enc_z = 1'b1;
    tick(8);
    enc_z = 1'b0;
    tick(8);
    chk("index_pulses", idx_cnt - i0, 1);
    chk("index_pos", int'(pos), 0);
    $display("index: pos=%0d pulses=%0d", pos, idx_cnt - i0);

    // 01 -> 00 -> 10 -> 00 leaves pos 1, direction CCW
    enc_a = 1'b0; enc_b = 1'b0; tick(8);
    enc_a = 1'b1; enc_b = 1'b0; tick(8);
    enc_a = 1'b0; enc_b = 1'b0; tick(8);
    chk("pre_coinc_pos", int'(pos), 1);
    chk("pre_coinc_dir", int'(dir), 0);

    // CW step coincident with index: position reloads, step and direction still update
    s0 = step_cnt; i0 = idx_cnt; b0 = both_cnt;
    enc_a = 1'b1; enc_z = 1'b1;
    tick(10);
    chk("coinc_pos", int'(pos), 0);
    chk("coinc_dir", int'(dir), 1);
    chk("coinc_steps", step_cnt - s0, 1);
    chk("coinc_same_cycle", both_cnt - b0, 1);
    $display("coincident: pos=%0d dir=%b steps=%0d idx=%0d", pos, dir, step_cnt - s0, idx_cnt - i0);
    enc_z = 1'b0;
    tick(6);

    // Rotate to state 10 at pos 4, then pulse reset for one cycle
    enc_a = 1'b1; enc_b = 1'b1; tick(8);
    enc_a = 1'b0; enc_b = 1'b1; tick(8);
    enc_a = 1'b0; enc_b = 1'b0; tick(8);
    enc_a = 1'b1; enc_b = 1'b0; tick(8);
    chk("pre_rst_pos", int'(pos), 4);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_pos", int'(pos), 0);
    chk("midrst_dir", int'(dir), 0);
    chk("midrst_step", int'(step), 0);
    chk("midrst_index", int'(index), 0);
    chk("midrst_err", int'(err), 0);
    $display("mid-reset: pos=%0d dir=%b step=%b index=%b err=%b", pos, dir, step, index, err);
    rst_n = 1'b1;
    s0 = step_cnt;
    tick(12);
    chk("hold_steps", step_cnt - s0, 0);
    chk("hold_pos", int'(pos), 0);
    enc_a = 1'b1; enc_b = 1'b1;
    tick(10);
    chk("post_rst_pos", int'(pos), 1);
    chk("post_rst_dir", int'(dir), 1);
    $display("post-reset step: pos=%0d dir=%b steps=%0d", pos, dir, step_cnt - s0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_enc_decoder.md
# quad_enc_decoder

Quadrature encoder front end: consumes raw A/B/Z levels from the JA header, synchronises and de-glitches them, decodes x4 quadrature into a wrapping position count with direction, step, index and error reporting. Sits directly between the I_JA pins and the logic in `top` that consumes position (LED/status display, velocity logic).

## Interface
- `CPR`, 14400: counts per revolution after x4 decode (3600-line encoder); position range 0..CPR-1.
- `POS_W`, 16: width of O_POS; must satisfy 2^POS_W >= CPR.
- `FILT_LEN`, 3: consecutive stable cycles required before a filtered input changes; minimum 1.
- `INDEX_RST`, 1: 1 = rising edge of filtered Z reloads position to 0; 0 = Z only reported.
- `I_CLK_100MHZ`  in  1  system clock; all logic on rising edge.
- `I_RST_N`  in  1  reset, synchronous, active-low.
- `I_ENC_A`  in  1  raw encoder channel A (asynchronous).
- `I_ENC_B`  in  1  raw encoder channel B (asynchronous).
- `I_ENC_Z`  in  1  raw encoder index (asynchronous).
- `I_CLR`  in  1  synchronous clear: O_POS <= 0, O_ERR <= 0.
- `O_POS`  out  POS_W  current position, 0..CPR-1.
- `O_DIR`  out  1  last valid step direction, 1 = CW (increment), 0 = CCW.
- `O_STEP`  out  1  one-cycle pulse per valid quadrature step.
- `O_INDEX`  out  1  one-cycle pulse on rising edge of filtered Z.
- `O_ERR`  out  1  sticky: illegal transition (A and B changed together) seen.

## Operation
- Per input: 2-FF synchroniser, then filter. Filter holds output `f`; counter counts cycles in which synchronised value != `f`, clears when equal; when mismatch has persisted FILT_LEN consecutive cycles, `f` <= synchronised value, counter <= 0.
- Quadrature state S = {A_f, B_f}. CW sequence 10 -> 11 -> 01 -> 00 -> 10 (A leads B); each CW transition: position +1, O_DIR <= 1, O_STEP pulse. Reverse transitions: position -1, O_DIR <= 0, O_STEP pulse.
- Both bits changed (10<->01, 11<->00): no count, no O_STEP, O_DIR unchanged, O_ERR <= 1 (held until I_CLR or reset).
- Wrap: +1 at CPR-1 -> 0; -1 at 0 -> CPR-1. Arithmetic never leaves 0..CPR-1.
- Decoder FSM: HOLD, RUN. Reset -> HOLD. In HOLD, previous-state register loads S every cycle, no counting, no O_STEP/O_ERR/O_INDEX; after FILT_LEN+2 cycles in HOLD -> RUN. RUN stays until reset. Prevents spurious step when encoder rests at non-00 state out of reset.
- Z: rising edge of Z_f (in RUN) pulses O_INDEX; if INDEX_RST=1 position <= 0.
- Same-cycle priority on position: reset > I_CLR > index reload > step. Step coincident with index reload: O_POS = 0, O_STEP and O_DIR still update. I_CLR coincident with illegal transition: O_ERR = 0.

## Timing
- Reset values: O_POS=0, O_DIR=0, O_STEP=0, O_INDEX=0, O_ERR=0; synchronisers, filters, filter counters, previous state = 0; FSM = HOLD.
- Latency: raw edge first sampled at clock edge 0 -> filtered value updates at edge FILT_LEN+1 -> O_POS/O_STEP/O_DIR/O_ERR registered at edge FILT_LEN+2.
- Pulses shorter than FILT_LEN cycles after synchronisation are rejected entirely.
- Max step rate: one state change per FILT_LEN+1 cycles; faster input is undefined.
- I_CLR effective at the edge it is sampled high; O_POS=0 visible next cycle.
- Reset mid-motion: outputs return to reset values at the first edge with I_RST_N low; after release, HOLD for FILT_LEN+2 cycles, then counting from 0.

## Structure
- Package `quad_enc_pkg`: 2-bit state constants (ST_00, ST_01, ST_10, ST_11), direction constants DIR_CW=1 / DIR_CCW=0, FSM state encoding (HOLD, RUN).
- Sub-module `enc_input_filter` (synchroniser + FILT_LEN filter, params FILT_LEN), instantiated three times for A, B, Z; decode/count/FSM in `quad_enc_decoder`.

## Test plan
- Reset, 20 idle cycles, then 8 CW steps at 4 cycles/state -> O_POS 0..8, O_DIR=1, exactly 8 O_STEP pulses, O_ERR=0.
- I_CLR, one CCW step -> O_POS=14399, O_DIR=0; one CW step -> O_POS=0.
- 2-cycle glitch on A while at state 00 (FILT_LEN=3) -> O_POS, O_DIR unchanged, no O_STEP.
- From 00 force A=B=1 together, hold 10 cycles -> O_ERR=1, O_POS unchanged, no O_STEP; I_CLR -> O_ERR=0, O_POS=0.
- O_POS=37, Z rising held 8 cycles -> one O_INDEX pulse, O_POS=0; repeat with coincident CW step -> O_POS=0, O_STEP=1, O_DIR=1.
- Encoder held at 10, reset pulsed low 1 cycle mid-rotation -> all outputs 0, no O_STEP during HOLD; next CW state 11 -> O_POS=1.
